// File: rtl/bloom_pkg.sv
// bloom_pkg: row layout, widths and encodings shared by the Bloom row scheduler blocks.
// Row layout, MSB to LSB: bloom buckets | bucket index | loop count.
package bloom_pkg;
    localparam int DATA_WIDTH     = 72;
    localparam int NUM_BUCKETS    = 14;
    localparam int BUCKET_SZ      = 4;
    localparam int BITS_SHIFT     = 4;
    localparam int BLOOM_INIT_POS = 16;
    localparam int ADDR_WIDTH     = 19;

    localparam int LOOP_W     = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int BLOOM_W    = DATA_WIDTH - BLOOM_INIT_POS;
    localparam int BLOOM_LSB  = BLOOM_INIT_POS;
    localparam int BUCKET_MSB = BLOOM_INIT_POS - 1;
    localparam int BUCKET_LSB = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int LOOP_MSB   = LOOP_W - 1;
    localparam int LOOP_LSB   = 0;

    typedef enum logic [1:0] {IDLE, RD, UPD, WR} state_t;
    typedef enum logic {OP_DATA, OP_ACK} op_t;
endpackage

// File: rtl/bloom_row_scheduler_if.sv
// bloom_row_scheduler_if: requester handshakes, lookup response, SRAM port and live time base.
interface bloom_row_scheduler_if;
    import bloom_pkg::*;

    logic                  data_req_vld;
    logic [ADDR_WIDTH-1:0] data_req_addr;
    logic                  data_req_rdy;
    logic                  ack_req_vld;
    logic [ADDR_WIDTH-1:0] ack_req_addr;
    logic                  ack_req_rdy;
    logic                  resp_vld;
    logic                  resp_hit;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_req;
    logic                  mem_rd_vld;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_wr_req;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_ack;
    logic [BITS_SHIFT-1:0] cur_bucket;
    logic [LOOP_W-1:0]     cur_loop;
    logic                  busy;

    modport master (
        input  data_req_vld, data_req_addr, ack_req_vld, ack_req_addr,
        input  mem_rd_vld, mem_rd_data, mem_wr_ack,
        output data_req_rdy, ack_req_rdy, resp_vld, resp_hit,
        output mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
        output cur_bucket, cur_loop, busy
    );

    modport slave (
        output data_req_vld, data_req_addr, ack_req_vld, ack_req_addr,
        output mem_rd_vld, mem_rd_data, mem_wr_ack,
        input  data_req_rdy, ack_req_rdy, resp_vld, resp_hit,
        input  mem_addr, mem_rd_req, mem_wr_req, mem_wr_data,
        input  cur_bucket, cur_loop, busy
    );
endinterface

// File: rtl/atualiza_linha.sv
// atualiza_linha: ages a row to the given time, shifting buckets toward the LSB by elapsed buckets.
// Anything a full row-length or more in the past (modulo loop wrap), or ahead of now, is cleared.
module atualiza_linha import bloom_pkg::*; (
    input  logic [DATA_WIDTH-1:0] row,
    input  logic [BITS_SHIFT-1:0] bucket,
    input  logic [LOOP_W-1:0]     loop,
    output logic [DATA_WIDTH-1:0] aged
);
    logic [LOOP_W-1:0]     loop_gap;
    logic [BITS_SHIFT+1:0] elapsed;
    logic                  stale;
    logic [BLOOM_W-1:0]    bloom;

    always_comb begin
        loop_gap = loop - row[LOOP_MSB:LOOP_LSB];
        elapsed  = (loop_gap == LOOP_W'(1) ? (BITS_SHIFT+2)'(NUM_BUCKETS) : '0)
                 + (BITS_SHIFT+2)'(bucket) - (BITS_SHIFT+2)'(row[BUCKET_MSB:BUCKET_LSB]);
        // A row ahead of now underflows elapsed and lands in the stale range.
        stale    = loop_gap > LOOP_W'(1) || elapsed >= (BITS_SHIFT+2)'(NUM_BUCKETS);
        bloom    = stale ? '0 : row[DATA_WIDTH-1:BLOOM_LSB] >> (32'(elapsed) * BUCKET_SZ);
        aged     = {bloom, bucket, loop};
    end
endmodule

// File: rtl/bloom_time_base.sv
// bloom_time_base: free-running tick counter driving the live bucket index and loop count.
module bloom_time_base import bloom_pkg::*; #(
    parameter logic [15:0] TICKS_PER_BUCKET = 16'd1000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [BITS_SHIFT-1:0] cur_bucket,
    output logic [LOOP_W-1:0]     cur_loop
);
    localparam logic [BITS_SHIFT-1:0] LAST_BUCKET = BITS_SHIFT'(NUM_BUCKETS - 1);

    logic [15:0] tick;
    logic        wrap;
    logic        last;

    assign wrap = tick == TICKS_PER_BUCKET - 16'd1;
    assign last = cur_bucket == LAST_BUCKET;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick       <= '0;
            cur_bucket <= '0;
            cur_loop   <= '0;
        end else begin
            tick <= wrap ? '0 : tick + 16'd1;
            if (wrap) begin
                cur_bucket <= last ? '0 : cur_bucket + 1'b1;
                cur_loop   <= last ? cur_loop + 1'b1 : cur_loop;
            end
        end
    end
endmodule

// File: rtl/bloom_row_scheduler.sv
// bloom_row_scheduler: arbitrates inserts and lookups, then read-age-(bump)-write each SRAM row.
module bloom_row_scheduler import bloom_pkg::*; #(
    parameter logic [15:0] TICKS_PER_BUCKET = 16'd1000
) (
    input logic                  clk,
    input logic                  reset_n,
    bloom_row_scheduler_if.master bus
);
    state_t                state;
    state_t                next_state;
    op_t                   op;
    op_t                   last_grant;
    logic                  grant_data;
    logic                  grant_ack;
    logic [BITS_SHIFT-1:0] cur_bucket;
    logic [LOOP_W-1:0]     cur_loop;
    logic [BITS_SHIFT-1:0] snap_bucket;
    logic [LOOP_W-1:0]     snap_loop;
    logic [DATA_WIDTH-1:0] rd_row;
    logic [DATA_WIDTH-1:0] aged;
    logic [DATA_WIDTH-1:0] bumped;
    logic [BUCKET_SZ-1:0]  top;

    bloom_time_base #(.TICKS_PER_BUCKET(TICKS_PER_BUCKET)) time_base (
        .clk        (clk),
        .reset_n    (reset_n),
        .cur_bucket (cur_bucket),
        .cur_loop   (cur_loop)
    );

    atualiza_linha aging (
        .row    (rd_row),
        .bucket (snap_bucket),
        .loop   (snap_loop),
        .aged   (aged)
    );

    assign top    = aged[DATA_WIDTH-1 -: BUCKET_SZ];
    assign bumped = {&top ? top : top + 1'b1, aged[DATA_WIDTH-BUCKET_SZ-1:0]};

    // Reset gates the grants so no ready is shown while reset is asserted.
    assign grant_data = reset_n && state == IDLE && bus.data_req_vld
                        && (!bus.ack_req_vld || last_grant == OP_ACK);
    assign grant_ack  = reset_n && state == IDLE && bus.ack_req_vld
                        && (!bus.data_req_vld || last_grant == OP_DATA);

    assign bus.data_req_rdy = grant_data;
    assign bus.ack_req_rdy  = grant_ack;
    assign bus.mem_rd_req   = state == RD;
    assign bus.mem_wr_req   = state == WR;
    assign bus.busy         = state != IDLE;
    assign bus.cur_bucket   = cur_bucket;
    assign bus.cur_loop     = cur_loop;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = grant_data || grant_ack ? RD : IDLE;
            RD:      next_state = bus.mem_rd_vld ? UPD : RD;
            UPD:     next_state = WR;
            WR:      next_state = bus.mem_wr_ack ? IDLE : WR;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            op              <= OP_DATA;
            last_grant      <= OP_ACK;
            snap_bucket     <= '0;
            snap_loop       <= '0;
            rd_row          <= '0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            bus.resp_vld    <= 1'b0;
            bus.resp_hit    <= 1'b0;
        end else begin
            state        <= next_state;
            bus.resp_vld <= 1'b0;
            if (grant_data || grant_ack) begin
                op           <= grant_data ? OP_DATA : OP_ACK;
                last_grant   <= grant_data ? OP_DATA : OP_ACK;
                bus.mem_addr <= grant_data ? bus.data_req_addr : bus.ack_req_addr;
                snap_bucket  <= cur_bucket;
                snap_loop    <= cur_loop;
            end
            if (state == RD && bus.mem_rd_vld)
                rd_row <= bus.mem_rd_data;
            if (state == UPD) begin
                bus.mem_wr_data <= op == OP_DATA ? bumped : aged;
                if (op == OP_ACK) begin
                    bus.resp_vld <= 1'b1;
                    bus.resp_hit <= |aged[DATA_WIDTH-1:BLOOM_LSB];
                end
            end
        end
    end
endmodule

// File: tb/tb_bloom_row_scheduler.sv
// tb_bloom_row_scheduler: directed scenarios with hand-computed rows, TICKS_PER_BUCKET = 4.
module tb_bloom_row_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   passed = 0;
    int   total = 0;

    bloom_row_scheduler_if bus();

    bloom_row_scheduler #(.TICKS_PER_BUCKET(16'd4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.data_req_vld = 1'b0;
        bus.ack_req_vld  = 1'b0;
        bus.mem_rd_vld   = 1'b0;
        bus.mem_wr_ack   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // SRAM responder for one transaction; reports what it saw, compares nothing itself.
    task automatic serve(input int rd_delay, input logic [71:0] rd_row, output logic ok,
                         output logic [18:0] raddr, output logic [18:0] waddr,
                         output logic [71:0] wr_row, output int lat, output logic rv,
                         output logic rh, output logic rv_after);
        int n = 0;
        ok = 1'b0; raddr = '0; waddr = '0; wr_row = '0; lat = 0; rv = 1'b0; rh = 1'b0; rv_after = 1'b0;
        while (!bus.mem_rd_req && n < 50) begin @(negedge clk); n++; end
        if (!bus.mem_rd_req) return;
        raddr = bus.mem_addr;
        repeat (rd_delay) @(negedge clk);
        bus.mem_rd_data = rd_row;
        bus.mem_rd_vld  = 1'b1;
        @(negedge clk);
        bus.mem_rd_vld = 1'b0;
        lat = 1;
        while (!bus.mem_wr_req && lat < 50) begin @(negedge clk); lat++; end
        if (!bus.mem_wr_req) return;
        waddr  = bus.mem_addr;
        wr_row = bus.mem_wr_data;
        rv     = bus.resp_vld;
        rh     = bus.resp_hit;
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        bus.mem_wr_ack = 1'b0;
        rv_after = bus.resp_vld;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        bus.data_req_vld = 1'b1; bus.data_req_addr = 19'd1;
        bus.ack_req_vld  = 1'b1; bus.ack_req_addr  = 19'd2;
        bus.mem_rd_vld = 1'b0; bus.mem_wr_ack = 1'b0; bus.mem_rd_data = '0;
        repeat (2) @(negedge clk);
        total++; if (bus.data_req_rdy !== 1'b0) $display("FAIL reset_data_rdy: got %b required 0", bus.data_req_rdy); else passed++;
        total++; if (bus.ack_req_rdy !== 1'b0) $display("FAIL reset_ack_rdy: got %b required 0", bus.ack_req_rdy); else passed++;
        total++; if (bus.mem_rd_req !== 1'b0) $display("FAIL reset_rd_req: got %b required 0", bus.mem_rd_req); else passed++;
        total++; if (bus.mem_wr_req !== 1'b0) $display("FAIL reset_wr_req: got %b required 0", bus.mem_wr_req); else passed++;
        total++; if (bus.cur_bucket !== 4'd0) $display("FAIL reset_bucket: got %0d required 0", bus.cur_bucket); else passed++;
        total++; if (bus.cur_loop !== 12'd0) $display("FAIL reset_loop: got %0d required 0", bus.cur_loop); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", bus.busy); else passed++;
        total++; if (bus.resp_vld !== 1'b0) $display("FAIL reset_resp_vld: got %b required 0", bus.resp_vld); else passed++;
        total++; if (bus.mem_addr !== 19'd0) $display("FAIL reset_mem_addr: got %h required 0", bus.mem_addr); else passed++;
        reset_n = 1'b1;
        #1;
        total++; if (bus.data_req_rdy !== 1'b1) $display("FAIL first_grant_data: got %b required 1", bus.data_req_rdy); else passed++;
        total++; if (bus.ack_req_rdy !== 1'b0) $display("FAIL first_grant_ack: got %b required 0", bus.ack_req_rdy); else passed++;
        reset_n = 1'b0;
        bus.data_req_vld = 1'b0;
        bus.ack_req_vld  = 1'b0;
    endtask

    task automatic test_time_base();
        do_reset();
        repeat (55) @(negedge clk);
        total++; if (bus.cur_bucket !== 4'd13) $display("FAIL tb_bucket13: got %0d required 13", bus.cur_bucket); else passed++;
        total++; if (bus.cur_loop !== 12'd0) $display("FAIL tb_loop0: got %0d required 0", bus.cur_loop); else passed++;
        @(negedge clk);
        total++; if (bus.cur_bucket !== 4'd0) $display("FAIL tb_bucket_wrap: got %0d required 0", bus.cur_bucket); else passed++;
        total++; if (bus.cur_loop !== 12'd1) $display("FAIL tb_loop_inc: got %0d required 1", bus.cur_loop); else passed++;
    endtask

    task automatic test_insert(input logic [18:0] addr, input logic [71:0] row_in, input logic [71:0] row_exp);
        logic ok, rv, rh, rva;
        logic [18:0] ra, wa;
        logic [71:0] wr;
        int lat;
        do_reset();
        @(negedge clk);
        bus.data_req_vld = 1'b1; bus.data_req_addr = addr;
        @(negedge clk);
        bus.data_req_vld = 1'b0;
        total++; if (bus.busy !== 1'b1) $display("FAIL ins_busy: got %b required 1", bus.busy); else passed++;
        serve(1, row_in, ok, ra, wa, wr, lat, rv, rh, rva);
        total++; if (ok !== 1'b1) $display("FAIL ins_done: got %b required 1", ok); else passed++;
        total++; if (ra !== addr) $display("FAIL ins_rd_addr: got %h required %h", ra, addr); else passed++;
        total++; if (wa !== addr) $display("FAIL ins_wr_addr: got %h required %h", wa, addr); else passed++;
        total++; if (wr !== row_exp) $display("FAIL ins_row: got %h required %h", wr, row_exp); else passed++;
        total++; if (lat !== 2) $display("FAIL ins_wr_latency: got %0d required 2", lat); else passed++;
        total++; if (rv !== 1'b0) $display("FAIL ins_no_resp: got %b required 0", rv); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL ins_idle: got %b required 0", bus.busy); else passed++;
    endtask

    task automatic test_lookup(input int wait_cycles, input logic [71:0] row_in,
                               input logic [71:0] row_exp, input logic hit_exp);
        logic ok, rv, rh, rva;
        logic [18:0] ra, wa;
        logic [71:0] wr;
        int lat;
        do_reset();
        repeat (wait_cycles) @(negedge clk);
        bus.ack_req_vld = 1'b1; bus.ack_req_addr = 19'd10;
        @(negedge clk);
        bus.ack_req_vld = 1'b0;
        serve(1, row_in, ok, ra, wa, wr, lat, rv, rh, rva);
        total++; if (ok !== 1'b1) $display("FAIL lk_done: got %b required 1", ok); else passed++;
        total++; if (wa !== 19'd10) $display("FAIL lk_wr_addr: got %h required 00a", wa); else passed++;
        total++; if (wr !== row_exp) $display("FAIL lk_row: got %h required %h", wr, row_exp); else passed++;
        total++; if (rv !== 1'b1) $display("FAIL lk_resp_vld: got %b required 1", rv); else passed++;
        total++; if (rh !== hit_exp) $display("FAIL lk_resp_hit: got %b required %b", rh, hit_exp); else passed++;
        total++; if (rva !== 1'b0) $display("FAIL lk_resp_pulse: got %b required 0", rva); else passed++;
        repeat (3) @(negedge clk);
        total++; if (bus.resp_hit !== hit_exp) $display("FAIL lk_hit_hold: got %b required %b", bus.resp_hit, hit_exp); else passed++;
    endtask

    task automatic test_back_to_back();
        logic ok, rv, rh, rva;
        logic [18:0] ra, wa;
        logic [71:0] wr;
        int lat;
        logic [18:0] exp_addr [4] = '{19'd7, 19'd9, 19'd7, 19'd9};
        do_reset();
        repeat (2) @(negedge clk);
        bus.data_req_vld = 1'b1; bus.data_req_addr = 19'd7;
        bus.ack_req_vld  = 1'b1; bus.ack_req_addr  = 19'd9;
        for (int i = 0; i < 4; i++) begin
            serve(i == 0 ? 4 : 1, 72'h0, ok, ra, wa, wr, lat, rv, rh, rva);
            if (i == 3) begin
                bus.data_req_vld = 1'b0;
                bus.ack_req_vld  = 1'b0;
            end
            total++; if (ok !== 1'b1) $display("FAIL b2b_done%0d: got %b required 1", i, ok); else passed++;
            total++; if (ra !== exp_addr[i]) $display("FAIL b2b_order%0d: got %h required %h", i, ra, exp_addr[i]); else passed++;
            total++; if (rv !== (i % 2 == 1)) $display("FAIL b2b_resp%0d: got %b required %b", i, rv, i % 2 == 1); else passed++;
            if (i == 0) begin
                total++; if (wr !== 72'h100000000000000000) $display("FAIL b2b_snapshot_row: got %h required 100000000000000000", wr); else passed++;
                total++; if (bus.cur_bucket !== 4'd2) $display("FAIL b2b_live_bucket: got %0d required 2", bus.cur_bucket); else passed++;
            end
        end
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle: got %b required 0", bus.busy); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        bus.data_req_vld = 1'b1; bus.data_req_addr = 19'd3;
        @(negedge clk);
        bus.data_req_vld = 1'b0;
        total++; if (bus.mem_rd_req !== 1'b1) $display("FAIL mid_rd_req: got %b required 1", bus.mem_rd_req); else passed++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.mem_rd_data = 72'hF00000000000000000;
        bus.mem_rd_vld  = 1'b1;
        @(negedge clk);
        bus.mem_rd_vld = 1'b0;
        bus.mem_wr_ack = 1'b1;
        @(negedge clk);
        bus.mem_wr_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", bus.busy); else passed++;
        total++; if (bus.mem_wr_req !== 1'b0) $display("FAIL mid_no_write: got %b required 0", bus.mem_wr_req); else passed++;
        total++; if (bus.resp_vld !== 1'b0) $display("FAIL mid_no_resp: got %b required 0", bus.resp_vld); else passed++;
    endtask

    initial begin
        bus.data_req_vld = 1'b0; bus.data_req_addr = '0;
        bus.ack_req_vld  = 1'b0; bus.ack_req_addr  = '0;
        bus.mem_rd_vld   = 1'b0; bus.mem_rd_data   = '0;
        bus.mem_wr_ack   = 1'b0;
        test_reset();
        test_time_base();
        test_insert(19'd5, 72'h000000000000000000, 72'h100000000000000000);
        test_insert(19'd6, 72'hF00000000000000000, 72'hF00000000000000000);
        test_lookup(9, 72'h300000000000000000, 72'h003000000000002000, 1'b1);
        test_lookup(61, 72'h300000000000000000, 72'h000000000000001001, 1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
